// File: rtl/morse_symbol_decoder.sv
// Morse key decoder: synchronizes and debounces a single key, times each press
// and release in Morse units, collects up to five dot/dash symbols and commits
// them as a 5-bit character code with a one-cycle shift strobe.
module morse_symbol_decoder #(
  parameter int UNIT_CYCLES  = 50_000_000,
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int DASH_UNITS   = 2,
  parameter int LETTER_UNITS = 3,
  parameter int WORD_UNITS   = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key,
  output logic [4:0] char_num,
  output logic       shift,
  output logic [2:0] sym_count,
  output logic       key_down
);

  localparam int CYC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [3:0] DASH_U   = 4'(DASH_UNITS);
  localparam logic [3:0] LETTER_U = 4'(LETTER_UNITS);
  localparam logic [3:0] WORD_U   = 4'(WORD_UNITS);
  localparam logic [4:0] CODE_ERR = 5'd27;

  typedef enum logic [2:0] {
    WAIT_UP,
    IDLE,
    PRESS,
    GAP,
    COMMIT,
    STROBE
  } state_t;

  state_t           state_q;
  logic             keyMeta_q, keySync_q;
  logic             keyDown_q, keyDown_d;
  logic [DEB_W-1:0] debCnt_q, debCnt_d;
  logic [CYC_W-1:0] cycCnt_q, cycCnt_d;
  logic [3:0]       unitCnt_q, unitCnt_d;
  logic             unitTick, keyToggle, keyFall;
  logic [4:0]       symBits_q;
  logic [2:0]       symCount_q;
  logic             ovf_q, armed_q;
  logic [4:0]       charNum_q;
  logic             shift_q;
  logic [1:0]       waitCnt_q;

  // Symbol pattern to character code. The newest symbol sits in the LSB, so the
  // first symbol of the letter is the highest used bit; unused high bits are 0.
  function automatic logic [4:0] lookupChar(input logic [2:0] cnt, input logic [4:0] bits);
    logic [4:0] code;
    code = CODE_ERR;
    case ({cnt, bits})
      8'b001_00000: code = 5'd5;   // E .
      8'b001_00001: code = 5'd20;  // T -
      8'b010_00000: code = 5'd9;   // I ..
      8'b010_00001: code = 5'd1;   // A .-
      8'b010_00010: code = 5'd14;  // N -.
      8'b010_00011: code = 5'd13;  // M --
      8'b011_00000: code = 5'd19;  // S ...
      8'b011_00001: code = 5'd21;  // U ..-
      8'b011_00010: code = 5'd18;  // R .-.
      8'b011_00011: code = 5'd23;  // W .--
      8'b011_00100: code = 5'd4;   // D -..
      8'b011_00101: code = 5'd11;  // K -.-
      8'b011_00110: code = 5'd7;   // G --.
      8'b011_00111: code = 5'd15;  // O ---
      8'b100_00000: code = 5'd8;   // H ....
      8'b100_00001: code = 5'd22;  // V ...-
      8'b100_00010: code = 5'd6;   // F ..-.
      8'b100_00100: code = 5'd12;  // L .-..
      8'b100_00110: code = 5'd16;  // P .--.
      8'b100_00111: code = 5'd10;  // J .---
      8'b100_01000: code = 5'd2;   // B -...
      8'b100_01001: code = 5'd24;  // X -..-
      8'b100_01010: code = 5'd3;   // C -.-.
      8'b100_01011: code = 5'd25;  // Y -.--
      8'b100_01100: code = 5'd26;  // Z --..
      8'b100_01101: code = 5'd17;  // Q --.-
      default:      code = CODE_ERR;
    endcase
    return code;
  endfunction

  // Debounce: the filtered level flips only after the synced key has disagreed
  // with it for DEB_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    keyDown_d = keyDown_q;
    debCnt_d  = '0;
    if (keySync_q != keyDown_q) begin
      if (debCnt_q == DEB_LAST) begin
        keyDown_d = keySync_q;
      end else begin
        debCnt_d = debCnt_q + 1'b1;
      end
    end
  end

  assign keyToggle = (keyDown_d != keyDown_q);
  assign keyFall   = keyToggle & keyDown_q;

  // Unit timebase: free-running cycle counter plus a saturating unit counter that
  // restarts on every filtered key edge so it measures the current press or gap.
  always_comb begin
    unitTick  = (cycCnt_q == CYC_LAST);
    cycCnt_d  = unitTick ? '0 : cycCnt_q + 1'b1;
    unitCnt_d = unitCnt_q;
    if (keyToggle) begin
      unitCnt_d = 4'd0;
    end else if (unitTick && (unitCnt_q != 4'hF)) begin
      unitCnt_d = unitCnt_q + 4'd1;
    end
  end

  // Input synchronizer, debounce and timebase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keyMeta_q <= 1'b0;
      keySync_q <= 1'b0;
      keyDown_q <= 1'b0;
      debCnt_q  <= '0;
      cycCnt_q  <= '0;
      unitCnt_q <= 4'd0;
    end else begin
      keyMeta_q <= key;
      keySync_q <= keyMeta_q;
      keyDown_q <= keyDown_d;
      debCnt_q  <= debCnt_d;
      cycCnt_q  <= cycCnt_d;
      unitCnt_q <= unitCnt_d;
    end
  end

  // Letter FSM: collects symbols, commits letters, emits one blank per idle period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_UP;
      symBits_q  <= 5'd0;
      symCount_q <= 3'd0;
      ovf_q      <= 1'b0;
      armed_q    <= 1'b0;
      charNum_q  <= 5'd0;
      shift_q    <= 1'b0;
      waitCnt_q  <= 2'd0;
    end else begin
      shift_q <= 1'b0;
      case (state_q)
        WAIT_UP: begin
          // Give the synchronizer time to see a key held through reset.
          if (waitCnt_q != 2'd3) begin
            waitCnt_q <= waitCnt_q + 2'd1;
          end else if (!keyDown_q && !keySync_q && (debCnt_q == '0)) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (keyDown_q) begin
            state_q <= PRESS;
          end else if (armed_q && (unitCnt_q >= WORD_U)) begin
            charNum_q <= 5'd0;
            shift_q   <= 1'b1;
            armed_q   <= 1'b0;
          end
        end
        PRESS: begin
          if (keyFall) begin
            if (symCount_q == 3'd5) begin
              ovf_q <= 1'b1;
            end else begin
              symBits_q  <= {symBits_q[3:0], (unitCnt_q >= DASH_U)};
              symCount_q <= symCount_q + 3'd1;
            end
            state_q <= GAP;
          end
        end
        GAP: begin
          if (keyDown_q) begin
            state_q <= PRESS;
          end else if (unitCnt_q >= LETTER_U) begin
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          charNum_q  <= ovf_q ? CODE_ERR : lookupChar(symCount_q, symBits_q);
          symBits_q  <= 5'd0;
          symCount_q <= 3'd0;
          ovf_q      <= 1'b0;
          armed_q    <= 1'b1;
          shift_q    <= 1'b1;
          state_q    <= STROBE;
        end
        STROBE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign char_num  = charNum_q;
  assign shift     = shift_q;
  assign sym_count = symCount_q;
  assign key_down  = keyDown_q;

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Bench for morse_symbol_decoder with a 4-cycle unit and 2-cycle debounce.
// A Morse-table model predicts every emitted code; a monitor checks char_num on
// every cycle and each shift pulse against the expected emit queue.
module tb_morse_symbol_decoder;

   localparam int UNIT = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       key;
   logic [4:0] char_num;
   logic       shift;
   logic [2:0] sym_count;
   logic       key_down;

   int numCompared = 0;
   int numMismatched = 0;
   int shiftCount = 0;
   int expQ[$];

   string morseTab[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                           "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                           "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                           "-.--", "--.."};

   morse_symbol_decoder #(
      .UNIT_CYCLES (UNIT),
      .DEB_CYCLES  (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key       (key),
      .char_num  (char_num),
      .shift     (shift),
      .sym_count (sym_count),
      .key_down  (key_down)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Reference decode: look the dot/dash string up in the ITU table.
   function automatic int decodeModel(input string m);
      if (m.len() > 5) return 27;
      for (int i = 0; i < 26; i++) begin
         if (morseTab[i] == m) return i + 1;
      end
      return 27;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      numCompared++;
      if (actual != expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Hold the raw key at a level for a number of Morse units, then settle past the sampling edge.
   task automatic applyStimulus(input logic level, input int units);
      key = level;
      repeat (units * UNIT) @(negedge clk);
      #1;
   endtask

   // Key out a symbol string with 1-unit intra-letter gaps; the key is left released.
   task automatic keySymbols(input string m);
      for (int i = 0; i < m.len(); i++) begin
         applyStimulus(1'b1, (m[i] == 8'h2d) ? 3 : 1);
         if (i < m.len() - 1) applyStimulus(1'b0, 1);
      end
   endtask

   // A letter with hand-computed code, checking symbol count, commit and the trailing blank.
   task automatic runLetter(input string m, input int expCode, input int expSyms);
      int base;
      base = shiftCount;
      expQ.push_back(expCode);
      expQ.push_back(0);
      keySymbols(m);
      applyStimulus(1'b0, 2);
      checkOutput({"sym_count in gap ", m}, int'(sym_count), expSyms);
      applyStimulus(1'b0, 4);
      checkOutput({"char_num after ", m}, int'(char_num), expCode);
      checkOutput({"sym_count cleared ", m}, int'(sym_count), 0);
      checkOutput({"one strobe ", m}, shiftCount - base, 1);
      applyStimulus(1'b0, 8);
      checkOutput({"blank after ", m}, int'(char_num), 0);
      checkOutput({"strobes with blank ", m}, shiftCount - base, 2);
   endtask

   // A letter whose code comes from the table model; the monitor checks the emit.
   task automatic sendLetter(input string m);
      expQ.push_back(decodeModel(m));
      expQ.push_back(0);
      keySymbols(m);
      applyStimulus(1'b0, 12);
   endtask

   // Monitor: every cycle out of reset, compare char_num to the model and check each strobe.
   initial begin
      int expChar;
      logic prevShift;
      expChar = 0;
      prevShift = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            expChar = 0;
            prevShift = 1'b0;
         end else begin
            if (shift) begin
               shiftCount++;
               checkOutput("shift pulse width", int'(prevShift), 0);
               if (expQ.size() == 0) begin
                  checkOutput("unexpected shift", 1, 0);
               end else begin
                  expChar = expQ.pop_front();
               end
            end
            checkOutput("char_num vs model", int'(char_num), expChar);
            prevShift = shift;
         end
      end
   end

   // Directed scenario sequence.
   initial begin
      int base;
      key = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset char_num", int'(char_num), 0);
      checkOutput("reset shift", int'(shift), 0);
      checkOutput("reset sym_count", int'(sym_count), 0);
      checkOutput("reset key_down", int'(key_down), 0);
      rst_n = 1'b1;

      // Key held through reset must be ignored; the following dot is a normal E.
      applyStimulus(1'b1, 3);
      applyStimulus(1'b0, 3);
      runLetter(".", 5, 1);

      // A, its blank, and no third emit while idle.
      runLetter(".-", 1, 2);
      base = shiftCount;
      applyStimulus(1'b0, 10);
      checkOutput("no second blank", shiftCount - base, 0);

      // Overflow and unmatched five-symbol pattern.
      runLetter("......", 27, 5);
      runLetter("-----", 27, 5);

      // Model-driven letters, including an unmatched 4-symbol pattern.
      sendLetter("-...");
      sendLetter("--.-");
      sendLetter("...-");
      sendLetter("-.--");
      sendLetter("..--");
      sendLetter("-");
      sendLetter(".-.");

      // One-cycle key glitch is filtered out.
      key = 1'b1;
      @(negedge clk);
      key = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         checkOutput("glitch key_down", int'(key_down), 0);
      end
      applyStimulus(1'b0, 5);
      checkOutput("glitch sym_count", int'(sym_count), 0);

      // Reset in the middle of a letter gap aborts with no strobe.
      keySymbols("...");
      applyStimulus(1'b0, 2);
      checkOutput("sym_count before abort", int'(sym_count), 3);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort char_num", int'(char_num), 0);
      checkOutput("abort shift", int'(shift), 0);
      checkOutput("abort sym_count", int'(sym_count), 0);
      checkOutput("abort key_down", int'(key_down), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b0, 12);
      checkOutput("sym_count after abort", int'(sym_count), 0);

      checkOutput("pending emits", expQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
